// File: rtl/booth_pkg.sv
// Shared types and sizing helpers for the sequential Booth multiplier.
// Build option: define BOOTH_RADIX4_EN for modified-Booth radix-4 recoding;
// left undefined, the multiplier retires one multiplier bit per cycle.
package booth_pkg;

`ifdef BOOTH_RADIX4_EN
  // Radix-4: two multiplier bits retired per iteration.
  localparam int RADIX_LOG2 = 2;
`else
  // Radix-2: one multiplier bit retired per iteration.
  localparam int RADIX_LOG2 = 1;
`endif

  // Control states of the iterative multiplier.
  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Accumulator action chosen by the recoder for one iteration.
  typedef enum logic [2:0] {
    NOP,
    ADD1,
    SUB1,
    ADD2,
    SUB2
  } op_t;

  // Operand width after extension: one extra bit so unsigned operands
  // survive signed recoding, rounded up to even for radix-4.
  function automatic int ext_width(input int width);
    int e;
    e = width + 1;
    if (RADIX_LOG2 == 2) begin
      e = 2 * ((e + 1) / 2);
    end
    return e;
  endfunction

  // Number of RUN cycles for one operation.
  function automatic int iter_count(input int width);
    return ext_width(width) / RADIX_LOG2;
  endfunction

endpackage

// File: rtl/booth_recoder.sv
// Booth recoder: maps the low multiplier bits plus the guard bit to an
// accumulator action. Purely combinational. Radix chosen by BOOTH_RADIX4_EN
// (radix-4 looks at {q1,q0,q-1}; radix-2 looks at {q0,q-1}).
module booth_recoder
  import booth_pkg::*;
(
  input  logic [RADIX_LOG2:0] i_bits,
  output op_t                 o_op
);

  // Decode the bit window into add/subtract of M or 2M.
  always_comb begin
    o_op = NOP;
`ifdef BOOTH_RADIX4_EN
    case (i_bits)
      3'b001, 3'b010: o_op = ADD1;
      3'b011:         o_op = ADD2;
      3'b100:         o_op = SUB2;
      3'b101, 3'b110: o_op = SUB1;
      default:        o_op = NOP;
    endcase
`else
    case (i_bits)
      2'b01:   o_op = ADD1;
      2'b10:   o_op = SUB1;
      default: o_op = NOP;
    endcase
`endif
  end

endmodule

// File: rtl/booth_mul_seq.sv
// Iterative Booth multiplier, signed or unsigned per operation, start/busy/done.
// Latency: done one cycle after iter_count(WIDTH) RUN cycles (WIDTH+1 radix-2).
// Build option BOOTH_RADIX4_EN selects radix-4; start is ignored while busy.
module booth_mul_seq
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               tc,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  // Extended operand width, accumulator width and shift per iteration.
  localparam int EX   = ext_width(WIDTH);
  localparam int AW   = EX + 2 * RADIX_LOG2 - 1 + (RADIX_LOG2 == 2 ? 0 : 0);
  localparam int SH   = RADIX_LOG2;
  localparam int N    = iter_count(WIDTH);
  localparam int CW   = $clog2(N + 1);
  localparam int CATW = AW + EX + 1;

  state_t               r_state;
  state_t               w_next;
  logic [EX-1:0]        r_m;
  logic [EX-1:0]        r_q;
  logic                 r_qm1;
  logic [AW-1:0]        r_acc;
  logic [CW-1:0]        r_cnt;
  logic [2*WIDTH-1:0]   r_product;

  logic                 w_accept;
  logic                 w_last;
  logic                 w_a_sign;
  logic                 w_b_sign;
  logic [EX-1:0]        w_a_ext;
  logic [EX-1:0]        w_b_ext;
  op_t                  w_op;
  logic [AW-1:0]        w_m_ext;
  logic [AW-1:0]        w_m2_ext;
  logic [AW-1:0]        w_addend;
  logic [AW-1:0]        w_acc_sum;
  logic [CATW-1:0]      w_cat;
  logic [CATW-1:0]      w_sh;
  logic [AW-1:0]        w_acc_nx;
  logic [EX-1:0]        w_q_nx;
  logic                 w_qm1_nx;

  // A new operation is taken only from IDLE or DONE.
  assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));
  // Final iteration: counter is about to reach zero.
  assign w_last   = (r_state == RUN) && (r_cnt == CW'(1));

  // Sign-extend for two's complement, zero-extend for unsigned, so the
  // signed recoding below is exact in both modes.
  assign w_a_sign = tc & a[WIDTH-1];
  assign w_b_sign = tc & b[WIDTH-1];
  assign w_a_ext  = {{(EX-WIDTH){w_a_sign}}, a};
  assign w_b_ext  = {{(EX-WIDTH){w_b_sign}}, b};

  booth_recoder u_recoder (
    .i_bits ({r_q[RADIX_LOG2-1:0], r_qm1}),
    .o_op   (w_op)
  );

  // Multiplicand widened to the accumulator, plus its double for radix-4.
  assign w_m_ext  = {{(AW-EX){r_m[EX-1]}}, r_m};
  assign w_m2_ext = w_m_ext << 1;

  // Select the partial product to add this iteration.
  always_comb begin
    w_addend = '0;
    case (w_op)
      ADD1:    w_addend = w_m_ext;
      SUB1:    w_addend = -w_m_ext;
      ADD2:    w_addend = w_m2_ext;
      SUB2:    w_addend = -w_m2_ext;
      default: w_addend = '0;
    endcase
  end

  // Accumulate, then arithmetic-shift {acc, Q, q-1} right by the radix step.
  assign w_acc_sum = r_acc + w_addend;
  assign w_cat     = {w_acc_sum, r_q, r_qm1};
  assign w_sh      = CATW'($signed(w_cat) >>> SH);
  assign w_acc_nx  = w_sh[CATW-1:EX+1];
  assign w_q_nx    = w_sh[EX:1];
  assign w_qm1_nx  = w_sh[0];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic: RUN until the counter expires, DONE for one cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next = RUN;
        end
      end
      RUN: begin
        if (w_last) begin
          w_next = DONE;
        end
      end
      DONE: begin
        w_next = start ? RUN : IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Datapath: load on accept, iterate in RUN, capture product on the last step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m       <= '0;
      r_q       <= '0;
      r_qm1     <= 1'b0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_product <= '0;
    end else if (w_accept) begin
      r_m   <= w_b_ext;
      r_q   <= w_a_ext;
      r_qm1 <= 1'b0;
      r_acc <= '0;
      r_cnt <= CW'(N);
    end else if (r_state == RUN) begin
      r_acc <= w_acc_nx;
      r_q   <= w_q_nx;
      r_qm1 <= w_qm1_nx;
      r_cnt <= r_cnt - CW'(1);
      if (w_last) begin
        r_product <= w_sh[2*WIDTH:1];
      end
    end
  end

  assign busy    = (r_state == RUN);
  assign done    = (r_state == DONE);
  assign product = r_product;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Scoreboard bench for booth_mul_seq at WIDTH=4, either radix build.
module tb_booth_mul_seq;

  localparam int W = 4;
  localparam int E = W + 1;
`ifdef BOOTH_RADIX4_EN
  localparam int NIT = (2 * ((E + 1) / 2)) / 2;
`else
  localparam int NIT = E;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic           tc = 1'b0;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [2*W-1:0] p;
    int             c;
  } exp_t;
  exp_t exp_q[$];
  logic [2*W-1:0] held = '0;

  booth_mul_seq #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .tc      (tc),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Reference: plain integer multiply of the operands interpreted per mode.
  function automatic logic [2*W-1:0] model(input logic t, input logic [W-1:0] x, input logic [W-1:0] y);
    longint sx;
    longint sy;
    longint p;
    sx = (t && x[W-1]) ? longint'(x) - (longint'(1) << W) : longint'(x);
    sy = (t && y[W-1]) ? longint'(y) - (longint'(1) << W) : longint'(y);
    p  = sx * sy;
    return p[2*W-1:0];
  endfunction

  task automatic push_exp(input logic t, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    e.p = model(t, x, y);
    e.c = cyc + NIT;
    exp_q.push_back(e);
  endtask

  // Called at posedge+1; returns at posedge+1 with busy low.
  task automatic wait_idle();
    int n;
    n = 0;
    while (busy === 1'b1 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 60) begin
      total++;
      bad++;
      $display("FAIL busy_timeout: busy still %0b after %0d cycles", busy, n);
    end
  endtask

  task automatic issue(input logic t, input logic [W-1:0] x, input logic [W-1:0] y);
    wait_idle();
    start = 1'b1; tc = t; a = x; b = y;
    @(posedge clk); #1;
    push_exp(t, x, y);
    start = 1'b0;
    tc = 1'($urandom); a = W'($urandom); b = W'($urandom);
    chk("busy_after_accept", busy, 1);
  endtask

  // Monitor: compare every done against the scoreboard, check hold and exclusivity.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      held = '0;
      exp_q.delete();
    end else begin
      chk("busy_done_excl", busy & done, 0);
      if (done) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got done=1 product=%0h required no done", product);
        end else begin
          e = exp_q.pop_front();
          chk("product", product, e.p);
          chk("latency", cyc, e.c);
          held = e.p;
        end
      end else begin
        chk("product_hold", product, held);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_product", product, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed corner values.
    issue(1'b1, 4'h8, 4'h8);
    issue(1'b1, 4'h7, 4'hD);
    issue(1'b1, 4'hF, 4'h1);
    issue(1'b0, 4'hF, 4'hF);
    issue(1'b0, 4'h8, 4'h0);
    wait_idle();
    repeat (3) begin @(posedge clk); #1; end

    // Start pulses while busy must be ignored.
    issue(1'b1, 4'h3, 4'h5);
    start = 1'b1; tc = 1'b0; a = 4'hF; b = 4'hE;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; tc = 1'b1; a = 4'h9; b = 4'h2;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle();
    repeat (3) begin @(posedge clk); #1; end

    // Start held high across DONE: second pair accepted straight from DONE.
    start = 1'b1; tc = 1'b1; a = 4'h5; b = 4'hA;
    @(posedge clk); #1;
    push_exp(1'b1, 4'h5, 4'hA);
    tc = 1'b0; a = 4'h9; b = 4'h6;
    wait_idle();
    @(posedge clk); #1;
    push_exp(1'b0, 4'h9, 4'h6);
    start = 1'b0;
    chk("b2b_busy", busy, 1);
    wait_idle();
    repeat (2) begin @(posedge clk); #1; end

    // Reset mid-RUN.
    issue(1'b1, 4'h6, 4'hB);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_product", product, 0);
    @(negedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2 * NIT + 2) begin @(posedge clk); #1; end
    issue(1'b0, 4'hD, 4'hB);

    // Exhaustive sweep, both modes, with occasional idle gaps.
    for (int t = 0; t < 2; t++) begin
      for (int x = 0; x < (1 << W); x++) begin
        for (int y = 0; y < (1 << W); y++) begin
          issue(t[0], x[W-1:0], y[W-1:0]);
          if ($urandom_range(0, 7) == 0) begin
            wait_idle();
            repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
          end
        end
      end
    end

    // Random operations with random gaps.
    for (int i = 0; i < 150; i++) begin
      issue(1'($urandom), W'($urandom), W'($urandom));
      if ($urandom_range(0, 2) == 0) begin
        wait_idle();
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
    end

    // Drain the scoreboard.
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d results outstanding, required 0", exp_q.size());
    end
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
